// File: rtl/debug_pipeline_controller.sv
// Run-control sequencer for the 5-stage MIPS pipeline.
// Gates the PC/pipeline clock-enable (free-run until halt, single-step, stop),
// counts enabled cycles, and streams a register-bank dump followed by the cycle
// count over a valid/ready interface using the bank's second read port.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cmd_valid/i_cmd     command strobe/code (00 STOP, 01 RUN, 10 STEP, 11 DUMP)
//   o_cmd_ready           command accepted when valid & ready (IDLE, RUN, HALTED)
//   i_halt_detected       HALT instruction reached WB
//   o_pipe_enable         clock-enable to PC and pipeline registers
//   o_dbg_reg_addr        debug read address into the register bank
//   i_dbg_reg_data        combinational read data for o_dbg_reg_addr
//   o_tx_valid/o_tx_data  dump word stream, i_tx_ready is the consumer ready
//   o_cycle_count         saturating count of cycles with o_pipe_enable=1
//   o_halted, o_busy      status flags
module debug_pipeline_controller #(
  parameter int unsigned LEN                  = 32,
  parameter int unsigned CANTIDAD_REGISTROS   = 32,
  parameter int unsigned NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
  parameter int unsigned NB_CMD               = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_cmd_valid,
  input  logic [NB_CMD-1:0]               i_cmd,
  output logic                            o_cmd_ready,
  input  logic                            i_halt_detected,
  output logic                            o_pipe_enable,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_dbg_reg_addr,
  input  logic [LEN-1:0]                  i_dbg_reg_data,
  output logic                            o_tx_valid,
  output logic [LEN-1:0]                  o_tx_data,
  input  logic                            i_tx_ready,
  output logic [LEN-1:0]                  o_cycle_count,
  output logic                            o_halted,
  output logic                            o_busy
);

  localparam int unsigned IdxW = NB_ADDRESS_REGISTROS + 1;
  // Last index selects the cycle count instead of a register.
  localparam logic [IdxW-1:0] IdxLast = IdxW'(CANTIDAD_REGISTROS);

  localparam logic [NB_CMD-1:0] CmdStop = NB_CMD'(0);
  localparam logic [NB_CMD-1:0] CmdRun  = NB_CMD'(1);
  localparam logic [NB_CMD-1:0] CmdStep = NB_CMD'(2);
  localparam logic [NB_CMD-1:0] CmdDump = NB_CMD'(3);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StHalted,
    StDumpLoad,
    StDumpSend
  } state_e;

  state_e              state_q, state_d;
  logic                ret_halted_q, ret_halted_d;  // dump return target
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                tx_valid_q, tx_valid_d;
  logic [LEN-1:0]      tx_data_q, tx_data_d;
  logic                pipe_en_q;
  logic                halted_q;
  logic                busy_q;
  logic [NB_ADDRESS_REGISTROS-1:0] addr_q;
  logic [LEN-1:0]      count_q;
  logic                cmd_fire;

  assign o_cmd_ready = (state_q == StIdle) || (state_q == StRun) || (state_q == StHalted);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;

  always_comb begin
    state_d      = state_q;
    ret_halted_d = ret_halted_q;
    idx_d        = idx_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          case (i_cmd)
            CmdRun:  state_d = StRun;
            CmdStep: state_d = StStep;
            CmdDump: begin
              state_d      = StDumpLoad;
              ret_halted_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        // Halt takes priority over a simultaneous STOP.
        if (i_halt_detected) begin
          state_d = StHalted;
        end else if (cmd_fire && (i_cmd == CmdStop)) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        state_d = i_halt_detected ? StHalted : StIdle;
      end
      StHalted: begin
        if (cmd_fire && (i_cmd == CmdDump)) begin
          state_d      = StDumpLoad;
          ret_halted_d = 1'b1;
        end
      end
      StDumpLoad: begin
        tx_data_d  = (idx_q < IdxLast) ? i_dbg_reg_data : count_q;
        tx_valid_d = 1'b1;
        state_d    = StDumpSend;
      end
      StDumpSend: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = ret_halted_q ? StHalted : StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StDumpLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      ret_halted_q <= 1'b0;
      idx_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      pipe_en_q    <= 1'b0;
      halted_q     <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ret_halted_q <= ret_halted_d;
      idx_q        <= idx_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      pipe_en_q    <= (state_d == StRun) || (state_d == StStep);
      halted_q     <= (state_d == StHalted);
      busy_q       <= (state_d == StRun) || (state_d == StStep) ||
                      (state_d == StDumpLoad) || (state_d == StDumpSend);
      // Address tracks the next index so it is valid throughout DUMP_LOAD.
      addr_q       <= idx_d[NB_ADDRESS_REGISTROS-1:0];
      if (pipe_en_q && (count_q != {LEN{1'b1}})) begin
        count_q <= count_q + LEN'(1);
      end
    end
  end

  assign o_pipe_enable  = pipe_en_q;
  assign o_dbg_reg_addr = addr_q;
  assign o_tx_valid     = tx_valid_q;
  assign o_tx_data      = tx_data_q;
  assign o_cycle_count  = count_q;
  assign o_halted       = halted_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_debug_pipeline_controller.sv
// Bench for debug_pipeline_controller; narrow LEN so counter saturation is reachable.
module tb_debug_pipeline_controller;
  localparam int unsigned LEN  = 8;
  localparam int unsigned NREG = 32;
  localparam int unsigned NBA  = 5;
  localparam int          SAT  = (1 << LEN) - 1;
  localparam logic [1:0] CSTOP = 2'd0, CRUN = 2'd1, CSTEP = 2'd2, CDUMP = 2'd3;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, halt, pipe_en, tx_valid, tx_ready, halted, busy;
  logic [1:0]     cmd;
  logic [NBA-1:0] dbg_addr;
  logic [LEN-1:0] dbg_data, tx_data, count;
  logic [LEN-1:0] bank [NREG];
  logic [LEN-1:0] got [$];
  int total = 0;
  int bad   = 0;

  assign dbg_data = bank[dbg_addr];
  always #5 clk = ~clk;

  debug_pipeline_controller #(
    .LEN(LEN), .CANTIDAD_REGISTROS(NREG), .NB_ADDRESS_REGISTROS(NBA), .NB_CMD(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
    .i_halt_detected(halt), .o_pipe_enable(pipe_en), .o_dbg_reg_addr(dbg_addr),
    .i_dbg_reg_data(dbg_data), .o_tx_valid(tx_valid), .o_tx_data(tx_data),
    .i_tx_ready(tx_ready), .o_cycle_count(count), .o_halted(halted), .o_busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = CSTOP; halt = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c);
    cmd = c; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in the first enabled RUN cycle; ends RUN on the n-th enabled cycle.
  // how: 0 halt, 1 stop, 2 halt+stop together. Junk RUN/STEP/DUMP commands are
  // sprinkled in earlier cycles and must be discarded.
  task automatic run_for(input int n, input int how);
    for (int e = 1; e <= n; e++) begin
      total++;
      if (pipe_en !== 1'b1) begin
        bad++; $display("FAIL run_enable cyc=%0d got=%0b exp=1", e, pipe_en);
      end
      if (e == n) begin
        cmd_valid = (how != 0);
        cmd       = CSTOP;
        halt      = (how != 1);
      end else begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd       = 2'($urandom_range(1, 3));
      end
      tick();
      cmd_valid = 1'b0; halt = 1'b0;
    end
  endtask

  // mode: 0 ready always high, 1 ready toggling 1010.., 2 random ready.
  task automatic run_dump(input int mode, input logic [LEN-1:0] cnt,
                          output int nwords, output int ncycles);
    logic prev_stall;
    logic [LEN-1:0] prev_data;
    got.delete();
    nwords = 0; ncycles = 0; prev_stall = 1'b0; prev_data = '0;
    issue(CDUMP);
    for (int cyc = 1; cyc <= 600 && nwords < int'(NREG) + 1; cyc++) begin
      if (prev_stall) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          bad++;
          $display("FAIL dump_hold got=%0b/%0h exp=1/%0h", tx_valid, tx_data, prev_data);
        end
      end
      total++;
      if (pipe_en !== 1'b0 || count !== cnt) begin
        bad++; $display("FAIL dump_frozen en=%0b cnt=%0d exp=0/%0d", pipe_en, count, cnt);
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 1);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        nwords++;
        ncycles = cyc;
      end
      tick();
    end
    tx_ready = 1'b0;
  endtask

  task automatic check_dump(input string tag, input logic [LEN-1:0] cnt, input int nwords);
    logic [LEN-1:0] exp;
    total++;
    if (nwords != int'(NREG) + 1) begin
      bad++; $display("FAIL %s_words got=%0d exp=%0d", tag, nwords, NREG + 1);
    end
    for (int i = 0; i < nwords && i <= int'(NREG); i++) begin
      exp = (i < int'(NREG)) ? bank[i] : cnt;
      total++;
      if (got[i] !== exp) begin
        bad++; $display("FAIL %s_word%0d got=%0h exp=%0h", tag, i, got[i], exp);
      end
    end
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL %s_valid_after got=%0b exp=0", tag, tx_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pipe_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%0b exp=0", pipe_en); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", tx_valid); end
    total++; if (tx_data !== '0) begin bad++; $display("FAIL rst_data got=%0h exp=0", tx_data); end
    total++; if (dbg_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", dbg_addr); end
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", cmd_ready); end
    // Reset in the middle of a run.
    issue(CRUN);
    repeat ($urandom_range(2, 6)) tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if (pipe_en !== 1'b0) begin bad++; $display("FAIL midrst_en got=%0b exp=0", pipe_en); end
    total++; if (count !== '0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got=%0b%0b exp=10", cmd_ready, busy);
    end
  endtask

  task automatic test_step();
    int n;
    do_reset();
    n = $urandom_range(4, 7);
    for (int k = 1; k <= n; k++) begin
      issue(CSTEP);
      total++;
      if (pipe_en !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL step_on%0d got=%0b%0b%0b exp=110", k, pipe_en, busy, cmd_ready);
      end
      tick();
      total++;
      if (pipe_en !== 1'b0 || cmd_ready !== 1'b1 || halted !== 1'b0) begin
        bad++; $display("FAIL step_off%0d got=%0b%0b%0b exp=010", k, pipe_en, cmd_ready, halted);
      end
      total++;
      if (count !== LEN'(k)) begin bad++; $display("FAIL step_count got=%0d exp=%0d", count, k); end
    end
    issue(CSTEP);
    halt = 1'b1; tick(); halt = 1'b0;
    total++;
    if (halted !== 1'b1 || count !== LEN'(n + 1)) begin
      bad++; $display("FAIL step_halt got=%0b/%0d exp=1/%0d", halted, count, n + 1);
    end
  endtask

  task automatic test_run_halt(input int k);
    do_reset();
    issue(CRUN);
    run_for(k, 0);
    total++;
    if (count !== LEN'(k) || halted !== 1'b1 || pipe_en !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL halt_state got=%0d/%0b%0b%0b exp=%0d/100", count, halted, pipe_en,
                      busy, k);
    end
    issue(CRUN); issue(CSTEP); issue(CSTOP); tick(); tick();
    total++;
    if (pipe_en !== 1'b0 || halted !== 1'b1 || count !== LEN'(k) || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL halt_sticky got=%0b%0b/%0d exp=01/%0d", pipe_en, halted, count, k);
    end
  endtask

  task automatic test_stop();
    int n, m;
    do_reset();
    n = 10;
    issue(CRUN);
    run_for(n, 1);
    total++;
    if (count !== LEN'(n) || pipe_en !== 1'b0 || halted !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL stop_state got=%0d/%0b%0b%0b exp=%0d/001", count, pipe_en, halted,
                      cmd_ready, n);
    end
    m = $urandom_range(1, 40);
    issue(CRUN);
    run_for(m, 1);
    total++;
    if (count !== LEN'(n + m)) begin bad++; $display("FAIL stop_resume got=%0d exp=%0d", count, n + m); end
  endtask

  task automatic test_simultaneous();
    int k;
    do_reset();
    k = $urandom_range(1, 15);
    issue(CRUN);
    run_for(k, 2);
    total++;
    if (halted !== 1'b1 || count !== LEN'(k) || pipe_en !== 1'b0) begin
      bad++; $display("FAIL simul got=%0b/%0d exp=1/%0d", halted, count, k);
    end
  endtask

  task automatic test_dump(input int mode, input int k, input logic use_ramp);
    int nw, nc;
    do_reset();
    for (int i = 0; i < int'(NREG); i++) bank[i] = use_ramp ? LEN'(3 * i) : LEN'($urandom);
    issue(CRUN);
    run_for(k, 0);
    run_dump(mode, LEN'(k), nw, nc);
    check_dump(mode == 1 ? "dump_alt" : "dump_rnd", LEN'(k), nw);
    total++;
    if (halted !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL dump_return got=%0b%0b%0b exp=101", halted, busy, cmd_ready);
    end
  endtask

  task automatic test_abort();
    int nw, nc, seen;
    do_reset();
    for (int i = 0; i < int'(NREG); i++) bank[i] = LEN'($urandom);
    issue(CDUMP);
    seen = 0;
    for (int c = 0; c < 100 && !(seen == 7 && tx_valid); c++) begin
      tx_ready = (seen < 7);
      if (tx_valid && tx_ready) seen++;
      tick();
    end
    tx_ready = 1'b0;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== bank[7]) begin
      bad++; $display("FAIL abort_word7 got=%0b/%0h exp=1/%0h", tx_valid, tx_data, bank[7]);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL abort_rst got=%0b%0b%0b exp=001", tx_valid, busy, cmd_ready);
    end
    run_dump(0, '0, nw, nc);
    check_dump("dump_idle", '0, nw);
    total++;
    if (nc != 2 * (int'(NREG) + 1)) begin
      bad++; $display("FAIL dump_rate got=%0d exp=%0d", nc, 2 * (NREG + 1));
    end
    total++;
    if (halted !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL dump_idle_ret got=%0b%0b%0b exp=001", halted, busy, cmd_ready);
    end
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    n = SAT + $urandom_range(5, 40);
    issue(CRUN);
    run_for(n, 1);
    total++;
    if (count !== LEN'(SAT)) begin bad++; $display("FAIL saturate got=%0d exp=%0d", count, SAT); end
  endtask

  initial begin
    for (int i = 0; i < int'(NREG); i++) bank[i] = '0;
    test_reset();
    test_step();
    test_run_halt(5);
    test_run_halt($urandom_range(1, 30));
    test_stop();
    test_simultaneous();
    test_dump(1, 5, 1'b1);
    test_dump(2, $urandom_range(1, 50), 1'b0);
    test_abort();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_pipeline_controller.md
Name: debug_pipeline_controller

Overview:
Run-control sequencer for the 5-stage MIPS pipeline, sitting between the debug command source and the datapath.
- Gates the pipeline/PC clock-enable for three modes: free-run until halt, single-step, and stop.
- Counts executed cycles.
- Sequences a full register-bank dump plus the cycle count out over a valid/ready stream, using the register bank's second read port.

Parameters:
LEN, 32, datapath/word width
CANTIDAD_REGISTROS, 32, number of architectural registers dumped
NB_ADDRESS_REGISTROS, $clog2(CANTIDAD_REGISTROS), register address width
NB_CMD, 2, command code width

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  reset, synchronous, active-high
i_cmd_valid  in  1  command strobe
i_cmd  in  NB_CMD  00=STOP, 01=RUN, 10=STEP, 11=DUMP
o_cmd_ready  out  1  command accepted on a cycle where i_cmd_valid & o_cmd_ready
i_halt_detected  in  1  HALT instruction has reached WB
o_pipe_enable  out  1  clock-enable to PC and all pipeline registers
o_dbg_reg_addr  out  NB_ADDRESS_REGISTROS  register bank debug read address
i_dbg_reg_data  in  LEN  combinational read data for o_dbg_reg_addr
o_tx_valid  out  1  dump word valid
o_tx_data  out  LEN  dump word
i_tx_ready  in  1  dump consumer ready
o_cycle_count  out  LEN  number of cycles with o_pipe_enable=1
o_halted  out  1  in HALTED state
o_busy  out  1  state is RUN, STEP or any DUMP state

Behaviour:
- Reset (i_rst=1 at a rising edge): state IDLE. o_pipe_enable=0, o_tx_valid=0, o_tx_data=0, o_dbg_reg_addr=0, o_cycle_count=0, o_halted=0, o_busy=0. Dump index=0, return flag=0. Reset overrides everything, including mid-run and mid-dump; a pending tx word is dropped.
- All outputs are registered except o_cmd_ready, which is decoded from state.
- States: IDLE, RUN, STEP, HALTED, DUMP_LOAD, DUMP_SEND.
- o_cmd_ready=1 in IDLE, RUN and HALTED; 0 otherwise.
- IDLE:
  - RUN -> RUN, o_pipe_enable=1 from the next cycle.
  - STEP -> STEP.
  - DUMP -> DUMP_LOAD with return=IDLE.
  - STOP -> no effect.
- RUN:
  - o_pipe_enable=1 each cycle.
  - i_halt_detected=1 sampled -> HALTED; o_pipe_enable=0 next cycle. The halt cycle itself is counted.
  - STOP accepted -> IDLE, o_pipe_enable=0 next cycle.
  - If STOP and halt arrive in the same cycle, halt wins (-> HALTED).
  - RUN, STEP and DUMP are accepted and discarded.
- STEP:
  - o_pipe_enable=1 for exactly one cycle.
  - Then -> HALTED if i_halt_detected=1 in that cycle, else IDLE.
- HALTED:
  - o_halted=1, o_pipe_enable=0.
  - DUMP -> DUMP_LOAD with return=HALTED.
  - RUN, STEP and STOP are accepted and ignored.
  - Exit only via reset.
- Dump sequence:
  - Index width is NB_ADDRESS_REGISTROS+1 and runs 0..CANTIDAD_REGISTROS.
  - DUMP_LOAD (1 cycle): o_dbg_reg_addr=index[NB_ADDRESS_REGISTROS-1:0]. o_tx_data captures i_dbg_reg_data if index<CANTIDAD_REGISTROS, else o_cycle_count. Then -> DUMP_SEND with o_tx_valid=1.
  - DUMP_SEND: o_tx_valid and o_tx_data are held stable until i_tx_ready=1 is sampled. On transfer: o_tx_valid=0 next cycle, index++. If index was CANTIDAD_REGISTROS, index clears and state -> return state; else -> DUMP_LOAD.
  - One dump = CANTIDAD_REGISTROS+1 words. With i_tx_ready tied high, throughput is 2 cycles/word.
  - o_pipe_enable=0 throughout a dump; o_cycle_count is frozen.
- Cycle counter:
  - Increments on every cycle where o_pipe_enable=1.
  - Saturates at all-ones, with no wrap.
  - Cleared only by reset.

Test Plan:
- Reset check: assert i_rst 2 cycles mid-RUN -> next cycle o_pipe_enable=0, o_cycle_count=0, state IDLE, o_cmd_ready=1.
- Single step: from IDLE, STEP -> o_pipe_enable high exactly 1 cycle, o_cycle_count=1, back in IDLE. Three more STEPs -> o_cycle_count=4.
- Run to halt: from reset, RUN; raise i_halt_detected on the 5th enabled cycle -> o_cycle_count=5, o_halted=1, o_pipe_enable=0. A subsequent RUN does not re-enable.
- Stop: RUN, then STOP after 10 enabled cycles -> o_cycle_count=10, IDLE. A later RUN resumes counting from 10.
- Dump with backpressure: bank model r[i]=3*i, count=5, HALTED; DUMP with i_tx_ready toggling 1010...
  - Exactly 33 transfers with data 0,3,...,93,5.
  - o_tx_data stable while valid & !ready.
  - Returns to HALTED.
- Simultaneous/abort: STOP and i_halt_detected in same RUN cycle -> HALTED. Assert reset during DUMP_SEND at word 7 -> o_tx_valid=0 next cycle, next DUMP restarts at r0.
